// File: rtl/prog_seq_det_pkg.sv
// prog_seq_det_pkg: shared sizing helpers and reset defaults for prog_sequence_detector
package prog_seq_det_pkg;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;
  localparam int DEF_LEN = 4;
  localparam logic DEF_OVERLAP = 1'b0;
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction
  function automatic logic [31:0] mask_of(input int len);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) m[i] = (i < len);
    return m;
  endfunction
endpackage

// File: rtl/prog_sequence_detector_sat_counter.sv
// sat_counter: saturating up-counter where clear coincident with an increment yields 1
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  logic [W-1:0] count_n;
  always_comb count_n = clr ? W'(inc) : (inc && count != '1) ? count + W'(1) : count;
  always_ff @(posedge clk)
    if (!reset_n) count <= '0;
    else count <= count_n;
endmodule

// File: rtl/prog_sequence_detector.sv
// prog_sequence_detector: runtime-programmable serial pattern detector with saturating match count
// Optional sticky detected flag built when SEQDET_STICKY_EN is defined; otherwise detected is tied 0.
module prog_sequence_detector
  import prog_seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(DEF_PATTERN),
  parameter int RST_LEN = DEF_LEN,
  parameter logic RST_OVERLAP = DEF_OVERLAP,
  localparam int LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             count_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             detected
);
  logic [PAT_W-1:0] hist, hist_n, pattern, mask;
  logic [LEN_W-1:0] fill, fill_n, len, len_clamped;
  logic overlap, hit;
  always_comb begin
    hist_n = {hist[PAT_W-2:0], in_bit};
    fill_n = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
    mask = PAT_W'(mask_of(int'(len)));
    len_clamped = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;
    hit = in_valid && !cfg_load && len != '0 && fill_n >= len && ((hist_n ^ pattern) & mask) == '0;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      hist <= '0;
      fill <= '0;
      match <= 1'b0;
      pattern <= RST_PATTERN;
      len <= LEN_W'(RST_LEN);
      overlap <= RST_OVERLAP;
    end else if (cfg_load) begin
      hist <= '0;
      fill <= '0;
      match <= 1'b0;
      pattern <= cfg_pattern;
      len <= len_clamped;
      overlap <= cfg_overlap;
    end else if (in_valid) begin
      hist <= hist_n;
      fill <= (hit && !overlap) ? '0 : fill_n;
      match <= hit;
    end else match <= 1'b0;
  sat_counter #(.W(CNT_W)) u_count (
    .clk(clk),
    .reset_n(reset_n),
    .inc(hit),
    .clr(count_clr),
    .count(match_count)
  );
`ifdef SEQDET_STICKY_EN
  // a hit wins over a coincident clear so the flag never misses a detection
  always_ff @(posedge clk)
    if (!reset_n) detected <= 1'b0;
    else detected <= hit || (detected && !count_clr);
`else
  assign detected = 1'b0;
`endif
endmodule

// File: tb/tb_prog_sequence_detector.sv
// tb_prog_sequence_detector: directed and randomized checks against a stream-level reference model
module tb_prog_sequence_detector;
  logic clk = 1'b0;
  logic reset_n = 1'b0, in_valid = 1'b0, in_bit = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b0, count_clr = 1'b0;
  logic [3:0] cfg_pattern = '0;
  logic [2:0] cfg_len = '0;
  logic match, detected;
  logic [7:0] match_count;
  int checks = 0, errors = 0;
  bit m_q[$];
  logic [3:0] m_pat;
  int m_len, m_since, m_cnt;
  bit m_ov, m_match, m_det;

  prog_sequence_detector dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .count_clr(count_clr),
    .match(match), .match_count(match_count), .detected(detected)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(input bit rn, v, b, ld, clr, input logic [3:0] p, input int l, input bit ov);
    bit hit;
    int cl;
    hit = 0;
    if (!rn) begin
      m_pat = 4'b1011; m_len = 4; m_ov = 0; m_q.delete(); m_since = 0; m_cnt = 0; m_det = 0;
    end else begin
      if (ld) begin
        cl = l & 7;
        m_pat = p; m_len = (cl > 4) ? 4 : cl; m_ov = ov; m_q.delete(); m_since = 0;
      end else if (v) begin
        m_q.push_back(b);
        if (m_q.size() > 8) void'(m_q.pop_front());
        m_since++;
        if (m_len > 0 && m_since >= m_len) begin
          hit = 1;
          for (int i = 0; i < m_len; i++) if (m_q[m_q.size() - 1 - i] != m_pat[i]) hit = 0;
        end
        if (hit && !m_ov) m_since = 0;
      end
      m_cnt = clr ? int'(hit) : (hit && m_cnt < 255) ? m_cnt + 1 : m_cnt;
`ifdef SEQDET_STICKY_EN
      m_det = hit || (m_det && !clr);
`else
      m_det = 0;
`endif
    end
    m_match = hit;
  endtask

  task automatic cyc(input bit rn, v, b, ld = 0, clr = 0, input logic [3:0] p = 0, input int l = 0, input bit ov = 0);
    reset_n = rn; in_valid = v; in_bit = b; cfg_load = ld; count_clr = clr;
    cfg_pattern = p; cfg_len = l[2:0]; cfg_overlap = ov;
    model(rn, v, b, ld, clr, p, l, ov);
    @(posedge clk);
    #1;
    check("match", int'(match), int'(m_match));
    check("match_count", int'(match_count), m_cnt);
    check("detected", int'(detected), int'(m_det));
  endtask

  task automatic send(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) cyc(1, 1, bits[i]);
  endtask

  task automatic load(input logic [3:0] p, input int l, input bit ov);
    cyc(1, 0, 0, 1, 0, p, l, ov);
  endtask

  initial begin
    cyc(0, 0, 0);
    cyc(0, 1, 1, 1, 0, 4'b0001, 1, 1);
    check("rst_match", int'(match), 0);
    check("rst_count", int'(match_count), 0);
    send(16'b1011011, 7);
    check("dflt_nonoverlap_cnt", int'(match_count), 1);
    load(4'b0101, 3, 1);
    send(16'b10101, 5);
    check("overlap_cnt", int'(match_count), 3);
    load(4'b0101, 3, 0);
    send(16'b10101, 5);
    check("nonoverlap_cnt", int'(match_count), 4);
    load(4'b1011, 4, 0);
    cyc(1, 1, 1); repeat (3) cyc(1, 0, 1);
    cyc(1, 1, 0); repeat (3) cyc(1, 0, 0);
    cyc(1, 1, 1); repeat (3) cyc(1, 0, 0);
    cyc(1, 1, 1);
    check("gap_match", int'(match), 1);
    send(16'b101, 3);
    cyc(1, 1, 1, 1, 0, 4'b1011, 4, 0);
    check("load_collide", int'(match), 0);
    send(16'b1, 1);
    check("load_flush", int'(match), 0);
    load(4'b0001, 1, 1);
    repeat (260) cyc(1, 1, 1);
    check("saturate", int'(match_count), 255);
    cyc(1, 1, 1, 0, 1);
    check("clr_hit", int'(match_count), 1);
    cyc(1, 1, 0, 0, 1);
    check("clr_only", int'(match_count), 0);
    load(4'b1111, 0, 1);
    repeat (20) cyc(1, 1, $urandom_range(0, 1));
    check("len0_cnt", int'(match_count), 0);
    load(4'b1011, 7, 1);
    send(16'b1011011, 7);
    check("len7_cnt", int'(match_count), 2);
    send(16'b10, 2);
    cyc(0, 1, 1, 1, 0, 4'b0001, 1, 1);
    send(16'b11, 2);
    check("mid_rst_nomatch", int'(match_count), 0);
    send(16'b1011, 4);
    check("mid_rst_match", int'(match), 1);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 3)
        cyc(1, $urandom_range(0, 1), $urandom_range(0, 1), 1, $urandom_range(0, 1),
            4'($urandom_range(0, 15)), $urandom_range(0, 7), $urandom_range(0, 1));
      else if ($urandom_range(0, 499) == 0)
        cyc(0, 1, 1);
      else
        cyc(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1), 0, $urandom_range(0, 49) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_sequence_detector.md
Name: prog_sequence_detector

Overview:
- Runtime-programmable serial bit-pattern detector, the parametrised successor of the team's fixed 4-bit Moore detector.
- Pattern length up to PAT_W, selectable overlapping or non-overlapping detection, per-bit valid qualifier, and a saturating match counter.
- Sits on a 1-bit serial stream (frame-sync / preamble search) and reports registered one-cycle match pulses.

Parameters:
- PAT_W, 4, maximum pattern length in bits (≥2).
- CNT_W, 8, match counter width.
- RST_PATTERN, 4'b1011 (zero-extended to PAT_W), pattern after reset; bit 0 is the newest (last-received) bit.
- RST_LEN, 4, pattern length after reset.
- RST_OVERLAP, 1'b0, overlap mode after reset.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_bit is sampled this cycle.
- in_bit  in  1  serial data bit.
- cfg_load  in  1  latch cfg_* and flush history.
- cfg_pattern  in  PAT_W  pattern; bit len-1 is the oldest bit, bit 0 the newest.
- cfg_len  in  LEN_W  pattern length; LEN_W = $clog2(PAT_W+1).
- cfg_overlap  in  1  1 = overlapping matches allowed.
- count_clr  in  1  clear match_count.
- match  out  1  registered one-cycle pulse per detection.
- match_count  out  CNT_W  saturating number of matches.
- detected  out  1  sticky flag (optional feature; tied 0 when disabled).

Behaviour:
- Reset (reset_n=0 at an edge):
  - hist=0, fill=0, match=0, match_count=0, detected=0.
  - pattern/len/overlap load RST_* values.
- State:
  - hist[PAT_W-1:0] is a shift register of received bits.
  - fill in 0..PAT_W counts valid bits since the last flush, saturating at PAT_W.
- Per edge with in_valid=1 and cfg_load=0:
  - hist_n = {hist[PAT_W-2:0], in_bit}
  - fill_n = min(fill+1, PAT_W)
  - hit = (len≠0) && (fill_n ≥ len) && ((hist_n ^ pattern) & mask(len)) == 0, where mask(len) is the low len bits set.
- match <= hit. Latency: match is high in the cycle after the edge that sampled the completing bit.
- On hit:
  - overlap=1: fill_n is kept.
  - overlap=0: fill <= 0, so the next match needs len fresh bits. hist still shifts.
- in_valid=0: hist and fill hold, match <= 0. Gaps in in_valid are transparent to matching.
- cfg_load=1:
  - Latch pattern, overlap, and len. cfg_len > PAT_W clamps to PAT_W; len=0 disables detection (match never asserts).
  - hist <= 0, fill <= 0, match <= 0.
  - A coincident in_valid bit is discarded. match_count is unaffected.
- match_count:
  - Increments on each hit and saturates at 2^CNT_W-1.
  - count_clr with no hit gives 0; count_clr coincident with a hit gives 1.
- Mid-stream reset: reset_n=0 overrides all inputs, including cfg_load and in_valid.
- Equivalence: the default configuration (1011, len 4, overlap 0) detects non-overlapping 1011.

Optional Feature:
- Macro SEQDET_STICKY_EN.
- Defined:
  - detected is set on the first hit and held.
  - Cleared only by reset or count_clr; count_clr coincident with a hit leaves detected=1.
  - cfg_load does not clear it.
- Undefined: no sticky register is built; the detected port remains and is tied to 0.

Decomposition:
- Package prog_seq_det_pkg holds:
  - LEN_W derivation function.
  - Default pattern/length constants.
  - mask_of(len) function.
- Sub-module sat_counter (parameter W; inc, clr, count; clr-with-inc yields 1) implements match_count.
- Comparator, shift register and fill logic stay in the top module.

Test Plan:
- Reset defaults, non-overlap: stream 1,0,1,1,0,1,1 with in_valid=1 → match pulses once (after bit 4); the second 1011 needs fresh bits, so there is no pulse at bit 7; match_count=1.
- Overlap: cfg_load pattern 101, len 3, overlap 1; stream 1,0,1,0,1 → match after bits 3 and 5, match_count=2. Same stream with overlap 0 → a single match after bit 3.
- Valid gaps and load collision:
  - Pattern 1011 with in_valid deasserted for 3 cycles between bits → still matches.
  - cfg_load coincident with the completing bit → no match, fill=0.
- Saturation and clear:
  - CNT_W=2, pattern 1, len 1, overlap 1, five 1s → match_count saturates at 3.
  - count_clr coincident with a hit → 1; count_clr alone → 0.
- Boundaries:
  - cfg_len=0 → no match on any stream.
  - cfg_len=7 with PAT_W=4 → behaves as len 4.
  - reset_n=0 in the middle of a 1011 → no match until four fresh bits arrive.
- With SEQDET_STICKY_EN: first hit sets detected; it stays 1 through later non-matching traffic and cfg_load; count_clr clears it. Without the macro, detected stays 0.
